// File: rtl/conv_mac_engine.sv
// Multi-pass convolution MAC: accepts one window/kernel/bias, accumulates LANES
// products per cycle over TAPS/LANES passes, then holds the result until taken.
module conv_mac_engine #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 9,
    parameter int LANES  = 3,
    parameter int SIGNED = 0,
    localparam int ACC_W = 2 * DATA_W + $clog2(TAPS) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [TAPS*DATA_W-1:0]   window_data,
    input  logic [TAPS*DATA_W-1:0]   kernel_data,
    input  logic [ACC_W-1:0]         bias,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     busy
);

    localparam int PASSES = TAPS / LANES;
    localparam int P_W    = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [P_W-1:0] P_LAST   = P_W'(PASSES - 1);
    localparam logic           SIGNED_B = (SIGNED != 0);

    generate
        if ((LANES < 1) || (TAPS % LANES != 0)) begin : g_bad_cfg
            $error("conv_mac_engine: TAPS must be a positive multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_reg;
    logic [TAPS*DATA_W-1:0]    window_reg;
    logic [TAPS*DATA_W-1:0]    kernel_reg;
    logic                      relu_reg;
    logic [P_W-1:0]            p_reg;
    logic [ACC_W-1:0]          acc_reg;
    logic [ACC_W-1:0]          out_sum_reg;
    logic                      out_valid_reg;

    logic [ACC_W-1:0]          lane_prod [LANES];
    logic [ACC_W-1:0]          pass_sum;
    logic [ACC_W-1:0]          acc_next;
    logic                      relu_hit;
    logic                      accept;

    // The operand registers shift down one pass per MAC cycle, so the lanes
    // always read the lowest LANES taps and need no variable indexing.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] a;
            logic [DATA_W-1:0] b;
            assign a = window_reg[gi*DATA_W +: DATA_W];
            assign b = kernel_reg[gi*DATA_W +: DATA_W];
            if (SIGNED_B) begin : g_signed
                logic signed [PROD_W-1:0] prod;
                assign prod = $signed(a) * $signed(b);
                assign lane_prod[gi] = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end else begin : g_unsigned
                logic [PROD_W-1:0] prod;
                assign prod = a * b;
                assign lane_prod[gi] = {{(ACC_W-PROD_W){1'b0}}, prod};
            end
        end
    endgenerate

    always_comb begin
        pass_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            pass_sum = pass_sum + lane_prod[i];
        end
    end

    assign acc_next = acc_reg + pass_sum;
    assign relu_hit = SIGNED_B && relu_reg && acc_next[ACC_W-1];
    assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            window_reg    <= '0;
            kernel_reg    <= '0;
            relu_reg      <= 1'b0;
            p_reg         <= '0;
            acc_reg       <= '0;
            out_sum_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            // Also covers the DONE handshake that coincides with a new window.
            window_reg    <= window_data;
            kernel_reg    <= kernel_data;
            relu_reg      <= relu_en;
            acc_reg       <= bias;
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
            state_reg     <= MAC;
        end else begin
            case (state_reg)
                MAC: begin
                    acc_reg    <= acc_next;
                    window_reg <= window_reg >> (LANES * DATA_W);
                    kernel_reg <= kernel_reg >> (LANES * DATA_W);
                    if (p_reg == P_LAST) begin
                        out_sum_reg   <= relu_hit ? '0 : acc_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        p_reg <= p_reg + P_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                IDLE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_sum   = out_sum_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == MAC);

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench: an unsigned and a signed engine share one stimulus stream;
// a 25-tap engine covers the wider configuration.
module tb_conv_mac_engine;

    localparam int DATA_W = 8;
    localparam int TAPS   = 9;
    localparam int LANES  = 3;
    localparam int PASSES = TAPS / LANES;
    localparam int ACC_W  = 2 * DATA_W + $clog2(TAPS) + 1;
    localparam int WTAPS  = 25;
    localparam int WACC_W = 2 * DATA_W + $clog2(WTAPS) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic relu_en = 1'b0;
    logic [TAPS*DATA_W-1:0] window_data = '0;
    logic [TAPS*DATA_W-1:0] kernel_data = '0;
    logic [ACC_W-1:0] bias = '0;
    logic in_ready_a, out_valid_a, busy_a;
    logic [ACC_W-1:0] out_sum_a;
    logic in_ready_b, out_valid_b, busy_b;
    logic [ACC_W-1:0] out_sum_b;

    logic in_valid_w = 1'b0;
    logic out_ready_w = 1'b1;
    logic relu_w = 1'b0;
    logic [WTAPS*DATA_W-1:0] win_w = '0;
    logic [WTAPS*DATA_W-1:0] ker_w = '0;
    logic [WACC_W-1:0] bias_w = '0;
    logic in_ready_w, out_valid_w, busy_w;
    logic [WACC_W-1:0] out_sum_w;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_accept = 0;
    int n_txn = 0;
    bit bp_on = 1'b0;

    logic [ACC_W-1:0] exp_u[$];
    logic [ACC_W-1:0] exp_s[$];
    int acc_q[$];

    always #5 clk = ~clk;

    conv_mac_engine #(.DATA_W(DATA_W), .TAPS(TAPS), .LANES(LANES), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .window_data(window_data), .kernel_data(kernel_data), .bias(bias),
        .relu_en(relu_en), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_sum(out_sum_a), .busy(busy_a)
    );

    conv_mac_engine #(.DATA_W(DATA_W), .TAPS(TAPS), .LANES(LANES), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .window_data(window_data), .kernel_data(kernel_data), .bias(bias),
        .relu_en(relu_en), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_sum(out_sum_b), .busy(busy_b)
    );

    conv_mac_engine #(.DATA_W(DATA_W), .TAPS(WTAPS), .LANES(5), .SIGNED(0)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .window_data(win_w), .kernel_data(ker_w), .bias(bias_w),
        .relu_en(relu_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_sum(out_sum_w), .busy(busy_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference: plain integer dot product plus bias, reduced modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [TAPS*DATA_W-1:0] w,
                                               input logic [TAPS*DATA_W-1:0] k,
                                               input logic [ACC_W-1:0] b,
                                               input bit relu, input bit sgn);
        longint s, x, y;
        logic [ACC_W-1:0] r;
        s = sgn ? longint'($signed(b)) : longint'(b);
        for (int i = 0; i < TAPS; i++) begin
            x = sgn ? longint'($signed(w[i*DATA_W +: DATA_W])) : longint'(w[i*DATA_W +: DATA_W]);
            y = sgn ? longint'($signed(k[i*DATA_W +: DATA_W])) : longint'(k[i*DATA_W +: DATA_W]);
            s = s + x * y;
        end
        r = s[ACC_W-1:0];
        if (sgn && relu && (s < 0)) r = '0;
        return r;
    endfunction

    function automatic logic [TAPS*DATA_W-1:0] fill(input logic [DATA_W-1:0] v);
        logic [TAPS*DATA_W-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return 8'h00;
            1: return 8'hff;
            2: return 8'h80;
            3: return 8'h7f;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    task automatic send(input logic [TAPS*DATA_W-1:0] w, input logic [TAPS*DATA_W-1:0] k,
                        input logic [ACC_W-1:0] b, input bit r);
        bit ok = 1'b0;
        window_data = w;
        kernel_data = k;
        bias = b;
        relu_en = r;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready_a) ok = 1'b1;
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs so an in-flight result that depends on them shows up.
        window_data = {TAPS{pick()}};
        kernel_data = {TAPS{pick()}};
        bias = ACC_W'($urandom);
        relu_en = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (exp_u.size() == 0 && !out_valid_a && !busy_a) return;
        end
        fail_now("drain_timeout");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: checks handshake rules every cycle and retires results in order.
    initial begin
        bit pending = 1'b0;
        bit first_now;
        logic exp_ready;
        logic [ACC_W-1:0] seen_sum = '0;
        logic [ACC_W-1:0] eu, es;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending = 1'b0;
            end else begin
                first_now = 1'b0;
                exp_ready = (!busy_a && !out_valid_a) || (out_valid_a && out_ready);
                check("in_ready_u", in_ready_a, exp_ready);
                check("in_ready_s", in_ready_b, exp_ready);
                if (out_valid_a && !pending) begin
                    if (acc_q.size() == 0) fail_now("unexpected_out_valid");
                    else check("latency", cyc - acc_q.pop_front(), PASSES);
                    pending = 1'b1;
                    seen_sum = out_sum_a;
                    first_now = 1'b1;
                end
                if (out_valid_a && out_ready) begin
                    if (exp_u.size() == 0) begin
                        fail_now("unexpected_result");
                    end else begin
                        eu = exp_u.pop_front();
                        es = exp_s.pop_front();
                        n_txn++;
                        $display("txn %0d: out_sum_u=0x%0h exp=0x%0h out_sum_s=0x%0h exp=0x%0h",
                                 n_txn, out_sum_a, eu, out_sum_b, es);
                        check("out_sum_u", out_sum_a, eu);
                        check("out_sum_s", out_sum_b, es);
                        check("out_valid_s", out_valid_b, 1'b1);
                        if (!first_now) check("hold_stable", out_sum_a, seen_sum);
                    end
                    pending = 1'b0;
                end
                if (in_valid && in_ready_a) begin
                    exp_u.push_back(model(window_data, kernel_data, bias, relu_en, 1'b0));
                    exp_s.push_back(model(window_data, kernel_data, bias, relu_en, 1'b1));
                    acc_q.push_back(cyc + 1);
                    n_accept++;
                end
            end
        end
    end

    initial begin
        #500000;
        fail_now("watchdog");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nv;
        int na;
        int n;
        bit found;
        logic [TAPS*DATA_W-1:0] w, k;

        #2 rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid_a, 1'b0);
        check("reset_out_sum", out_sum_a, 0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_in_ready", in_ready_a, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        out_ready = 1'b1;
        send(fill(8'd1), fill(8'd1), '0, 1'b0);
        drain();
        check("idle_in_ready", in_ready_a, 1'b1);
        send(fill(8'hff), fill(8'hff), '0, 1'b0);
        drain();
        send(fill(8'h80), fill(8'h7f), ACC_W'(5), 1'b0);
        send(fill(8'h80), fill(8'h7f), ACC_W'(5), 1'b1);
        drain();

        // Downstream stall with the next window already waiting.
        out_ready = 1'b0;
        send(fill(8'd3), fill(8'd4), ACC_W'(7), 1'b0);
        fork
            send(fill(8'd9), fill(8'd10), ACC_W'(1), 1'b0);
            begin
                found = 1'b0;
                for (int i = 0; i < 20 && !found; i++) begin
                    @(negedge clk);
                    if (out_valid_a) found = 1'b1;
                end
                check("stall_valid_seen", found, 1'b1);
                na = n_accept;
                repeat (10) @(posedge clk);
                #1;
                check("stall_no_accept", n_accept, na);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset during the second MAC cycle.
        send(fill(8'd2), fill(8'd2), '0, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid_a, 1'b0);
        check("mid_rst_out_sum", out_sum_a, 0);
        check("mid_rst_out_sum_s", out_sum_b, 0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_in_ready", in_ready_a, 1'b1);
        exp_u.delete();
        exp_s.delete();
        acc_q.delete();
        nv = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid_a) nv++;
        end
        check("mid_rst_no_valid", nv, 0);
        window_data = fill(8'd5);
        kernel_data = fill(8'd6);
        bias = ACC_W'(11);
        relu_en = 1'b0;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("accept_after_reset", busy_a, 1'b1);
        in_valid = 1'b0;
        drain();

        // Wide configuration: 25 taps over 5 lanes.
        for (int i = 0; i < WTAPS; i++) begin
            win_w[i*DATA_W +: DATA_W] = DATA_W'(i);
            ker_w[i*DATA_W +: DATA_W] = 8'd1;
        end
        bias_w = '0;
        in_valid_w = 1'b1;
        @(negedge clk);
        check("wide_in_ready", in_ready_w, 1'b1);
        @(posedge clk);
        #1 in_valid_w = 1'b0;
        n = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (out_valid_w) begin
                found = 1'b1;
                n = i;
            end
        end
        check("wide_latency", n, 5);
        check("wide_sum", out_sum_w, 300);

        // Randomized traffic with random downstream backpressure.
        bp_on = 1'b1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < TAPS; i++) begin
                w[i*DATA_W +: DATA_W] = pick();
                k[i*DATA_W +: DATA_W] = pick();
            end
            send(w, k, ACC_W'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bp_on = 1'b0;
        #0 out_ready = 1'b1;
        drain();
        check("all_results_retired", exp_u.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
